// File: rtl/sim_harness_ctrl.sv
// sim_harness_ctrl: stretched core reset, then commit monitoring with run/halt/timeout status.
// Latency: every output is registered and reflects the cycle presented one edge earlier.
// Backpressure: none; validCommit is sampled every cycle and only acted on in RUN.
//
// Optional feature macro: HARNESS_PC_CHECK_EN (first-commit PC check driving pcError).
// Ports:
//   clk, globalReset            clock and synchronous active-high harness reset
//   validCommit[CH]             per-channel commit valid
//   commitPC[CH*(WIDTH+1)]      channel i PC at [i*(WIDTH+1) +: WIDTH+1]
//   haltPC                      PC whose commit ends the run
//   cpuReset, running           core reset, high while in RUN
//   halted, timeout, pcError    sticky status flags, cleared only by globalReset
//   commitCount, cycleCount     saturating retired-instruction and RUN-cycle counters
module sim_harness_ctrl #(
  parameter int             WIDTH      = 31,
  parameter int             CH         = 2,
  parameter int             RST_CYCLES = 4,
  parameter int             TIMEOUT    = 1024,
  parameter int             CNT_W      = 31,
  parameter logic [WIDTH:0] RESET_PC   = '0
) (
  input  logic                      clk,
  input  logic                      globalReset,
  input  logic [CH-1:0]             validCommit,
  input  logic [CH*(WIDTH+1)-1:0]   commitPC,
  input  logic [WIDTH:0]            haltPC,
  output logic                      cpuReset,
  output logic                      running,
  output logic                      halted,
  output logic                      timeout,
  output logic                      pcError,
  output logic [CNT_W:0]            commitCount,
  output logic [CNT_W:0]            cycleCount
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WD_W   = $clog2(TIMEOUT);
  localparam int POP_W  = $clog2(CH + 1);

  typedef enum logic [1:0] {HOLD, RUN, HALTED, TIMEDOUT} state_e;

  state_e            state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [WD_W-1:0]   wd_cnt_q;
  logic              cpu_reset_q, running_q, halted_q, timeout_q;
  logic [CNT_W:0]    commit_cnt_q, cycle_cnt_q;

  logic [POP_W-1:0]  pop_d;
  logic              any_commit_d, halt_hit_d, wd_expire_d;
  logic [CNT_W+1:0]  commit_sum_d;
  logic [CNT_W:0]    commit_cnt_d, cycle_cnt_d;

  // Count asserted channels and look for the halt PC on any of them.
  always_comb begin
    pop_d      = '0;
    halt_hit_d = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (validCommit[i]) begin
        pop_d = pop_d + POP_W'(1);
        if (commitPC[i*(WIDTH+1) +: WIDTH+1] == haltPC) halt_hit_d = 1'b1;
      end
    end
  end

  assign any_commit_d = |validCommit;
  // Extra carry bit detects overflow so the counter pins at all-ones.
  assign commit_sum_d = {1'b0, commit_cnt_q} + (CNT_W+2)'(pop_d);
  assign commit_cnt_d = commit_sum_d[CNT_W+1] ? '1 : commit_sum_d[CNT_W:0];
  assign cycle_cnt_d  = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + (CNT_W+1)'(1);
  assign wd_expire_d  = !any_commit_d && (wd_cnt_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (globalReset) begin
      state_q      <= HOLD;
      hold_cnt_q   <= '0;
      wd_cnt_q     <= '0;
      cpu_reset_q  <= 1'b1;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      commit_cnt_q <= '0;
      cycle_cnt_q  <= '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
            state_q     <= RUN;
            cpu_reset_q <= 1'b0;
            running_q   <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        RUN: begin
          cycle_cnt_q  <= cycle_cnt_d;
          commit_cnt_q <= commit_cnt_d;
          wd_cnt_q     <= any_commit_d ? '0 : wd_cnt_q + WD_W'(1);
          // Halt wins if both ever flag together (a commit also clears the watchdog).
          if (halt_hit_d) begin
            state_q   <= HALTED;
            running_q <= 1'b0;
            halted_q  <= 1'b1;
          end else if (wd_expire_d) begin
            state_q   <= TIMEDOUT;
            running_q <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          // HALTED / TIMEDOUT hold everything until globalReset.
        end
      endcase
    end
  end

  assign cpuReset    = cpu_reset_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign commitCount = commit_cnt_q;
  assign cycleCount  = cycle_cnt_q;

`ifdef HARNESS_PC_CHECK_EN
  logic           first_seen_q, pc_error_q;
  logic [WIDTH:0] first_pc_d;

  // Lowest-indexed valid channel holds the oldest commit of the cycle.
  always_comb begin
    first_pc_d = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (validCommit[i]) first_pc_d = commitPC[i*(WIDTH+1) +: WIDTH+1];
    end
  end

  always_ff @(posedge clk) begin
    if (globalReset) begin
      first_seen_q <= 1'b0;
      pc_error_q   <= 1'b0;
    end else if (state_q == RUN && any_commit_d && !first_seen_q) begin
      first_seen_q <= 1'b1;
      if (first_pc_d != RESET_PC) pc_error_q <= 1'b1;
    end
  end

  assign pcError = pc_error_q;
`else
  assign pcError = 1'b0;
`endif

endmodule

// File: tb/tb_sim_harness_ctrl.sv
module tb_sim_harness_ctrl;

  localparam int          W     = 31;
  localparam int          CH    = 2;
  localparam int          RST   = 4;
  localparam int          TMO   = 16;
  localparam int          CNT_W = 5;
  localparam int          MAXC  = (1 << (CNT_W + 1)) - 1;
  localparam logic [31:0] HALT  = 32'h40;
  localparam logic [31:0] RPC   = 32'h0;

  logic              clk = 1'b0;
  logic              globalReset;
  logic [CH-1:0]     validCommit;
  logic [CH*32-1:0]  commitPC;
  logic [31:0]       haltPC;
  logic              cpuReset, running, halted, timeout, pcError;
  logic [CNT_W:0]    commitCount, cycleCount;

  sim_harness_ctrl #(
    .WIDTH(W), .CH(CH), .RST_CYCLES(RST), .TIMEOUT(TMO), .CNT_W(CNT_W), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .globalReset(globalReset), .validCommit(validCommit),
    .commitPC(commitPC), .haltPC(haltPC), .cpuReset(cpuReset), .running(running),
    .halted(halted), .timeout(timeout), .pcError(pcError),
    .commitCount(commitCount), .cycleCount(cycleCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       cpu_reset;
    logic       running;
    logic       halted;
    logic       timeout;
    logic       pc_error;
    logic [7:0] commits;
    logic [7:0] cycles;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: counts edges and events rather than tracking an FSM.
  int low_edges;   // edges with globalReset low since the last reset
  int m_commits, m_cycles, idle;
  bit m_halted, m_tmo, m_seen, m_pcerr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] rpc();
    return 32'h100 + (32'($urandom_range(0, 255)) << 2);
  endfunction

  task automatic model_edge(input bit rst, input logic [1:0] v,
                            input logic [31:0] p0, input logic [31:0] p1);
    int n;
    if (rst) begin
      low_edges = 0; m_commits = 0; m_cycles = 0; idle = 0;
      m_halted = 0; m_tmo = 0; m_seen = 0; m_pcerr = 0;
    end else if (low_edges < RST) begin
      low_edges++;
    end else if (!m_halted && !m_tmo) begin
      n = int'(v[0]) + int'(v[1]);
      m_cycles  = (m_cycles + 1 > MAXC) ? MAXC : m_cycles + 1;
      m_commits = (m_commits + n > MAXC) ? MAXC : m_commits + n;
      if (n > 0) begin
        idle = 0;
        if (!m_seen) begin
          m_seen  = 1;
          m_pcerr = ((v[0] ? p0 : p1) != RPC);
        end
        if ((v[0] && p0 == HALT) || (v[1] && p1 == HALT)) m_halted = 1;
      end else begin
        idle++;
        if (idle >= TMO) m_tmo = 1;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.cpu_reset = (low_edges < RST);
    e.running   = !e.cpu_reset && !m_halted && !m_tmo;
    e.halted    = m_halted;
    e.timeout   = m_tmo;
`ifdef HARNESS_PC_CHECK_EN
    e.pc_error  = m_pcerr;
`else
    e.pc_error  = 1'b0;
`endif
    e.commits   = 8'(m_commits);
    e.cycles    = 8'(m_cycles);
    return e;
  endfunction

  task automatic step(input bit rst, input logic [1:0] v,
                      input logic [31:0] p0, input logic [31:0] p1);
    @(negedge clk);
    globalReset = rst;
    validCommit = v;
    commitPC    = {p1, p0};
    model_edge(rst, v, p0, p1);
    exp_q.push_back(model_out());
  endtask

  task automatic reset_and_hold(input int rst_cycles);
    for (int i = 0; i < rst_cycles; i++) step(1, 2'($urandom), rpc(), rpc());
    // Commits during hold must be ignored.
    for (int i = 0; i < RST; i++) step(0, 2'($urandom), rpc(), rpc());
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, rpc(), rpc());
  endtask

  // Monitor: outputs are valid every cycle; compare just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cpuReset",    32'(cpuReset),    32'(e.cpu_reset));
        chk("running",     32'(running),     32'(e.running));
        chk("halted",      32'(halted),      32'(e.halted));
        chk("timeout",     32'(timeout),     32'(e.timeout));
        chk("pcError",     32'(pcError),     32'(e.pc_error));
        chk("commitCount", 32'(commitCount), 32'(e.commits));
        chk("cycleCount",  32'(cycleCount),  32'(e.cycles));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL hang_guard: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dens, len;
    logic [1:0]  v;
    logic [31:0] p0, p1;
    globalReset = 1'b0;
    validCommit = '0;
    commitPC    = '0;
    haltPC      = HALT;

    // Reset sequence plus multi-commit counting, first commit at RESET_PC.
    reset_and_hold(2);
    step(0, 2'b11, 32'h0, rpc());
    step(0, 2'b11, rpc(), rpc());
    step(0, 2'b11, rpc(), rpc());
    step(0, 2'b01, rpc(), rpc());
    step(0, 2'b01, rpc(), rpc());
    idle_steps(3);

    // Mid-run reset after five commits.
    reset_and_hold(1);
    step(0, 2'b11, rpc(), rpc());
    step(0, 2'b11, rpc(), rpc());
    step(0, 2'b01, rpc(), rpc());
    step(1, 2'b11, rpc(), rpc());
    for (int i = 0; i < RST; i++) step(0, 2'b11, rpc(), rpc());

    // First commit at a wrong PC, then halt on channel 1 with channel 0 committing.
    step(0, 2'b11, 32'h4, rpc());
    idle_steps(2);
    step(0, 2'b11, rpc(), HALT);
    for (int i = 0; i < 5; i++) step(0, 2'b11, rpc(), rpc());

    // Halt on channel 0 while channel 1 also commits.
    reset_and_hold(1);
    step(0, 2'b11, HALT, rpc());
    idle_steps(3);

    // Watchdog with no commits, then with a single commit at RUN cycle 10.
    reset_and_hold(1);
    idle_steps(TMO + 4);
    reset_and_hold(1);
    idle_steps(9);
    step(0, 2'b10, rpc(), 32'h0);
    idle_steps(TMO + 4);

    // Saturation of both counters.
    reset_and_hold(1);
    for (int i = 0; i < 70; i++) step(0, 2'b11, rpc(), rpc());

    // Randomised runs with varied commit density and occasional mid-run resets.
    for (int it = 0; it < 8; it++) begin
      reset_and_hold($urandom_range(1, 3));
      dens = (it % 2 == 0) ? 4 : 24;
      len  = $urandom_range(80, 160);
      for (int i = 0; i < len; i++) begin
        v[0] = ($urandom_range(0, dens - 1) < 3);
        v[1] = ($urandom_range(0, dens - 1) < 3);
        p0 = ($urandom_range(0, 59) == 0) ? HALT : (($urandom_range(0, 3) == 0) ? 32'h0 : rpc());
        p1 = ($urandom_range(0, 59) == 0) ? HALT : rpc();
        step(($urandom_range(0, 149) == 0), v, p0, p1);
      end
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
